// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmit FSM states and the
// bit-period helper used by both the transmitter and the future receiver.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  function automatic int bit_cycles(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: pulses tick for one cycle every CYCLES enabled cycles;
// clr holds the count at zero so the next bit starts on a full period.
module uart_baud_tick #(
  parameter int CYCLES = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || (en && cnt == LAST)) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);
endmodule

// File: rtl/uart_message_sender.sv
// Buffered UART message transmitter: sends the first i_len buffer entries
// as framed characters back to back, optionally repeating the message.
module uart_message_sender
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [AW-1:0]        i_wr_addr,
  input  logic [DATA_BITS-1:0] i_wr_data,
  input  logic [AW:0]          i_len,
  input  logic                 i_start,
  input  logic                 i_repeat,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [AW-1:0]        o_char_idx,
  output uart_state_t          o_state
);
  localparam int BIT_CYCLES = bit_cycles(CLK_HZ, BAUD);
  localparam int LW = AW + 1;
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [DATA_BITS-1:0] buffer [DEPTH];
  uart_state_t          state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [3:0]           bit_cnt;
  logic [LW-1:0]        len_q;
  logic [LW-1:0]        eff_len;
  logic [AW-1:0]        next_idx;
  logic                 last_char;
  logic                 tick;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY == PAR_ODD);
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_wr_en) buffer[i_wr_addr] <= i_wr_data;
  end

  assign eff_len   = (i_len > DEPTH_L) ? DEPTH_L : i_len;
  assign next_idx  = o_char_idx + AW'(1);
  assign last_char = ({1'b0, o_char_idx} == len_q - LW'(1));
  assign o_state   = state;

  uart_baud_tick #(.CYCLES(BIT_CYCLES)) u_tick (
    .clk  (i_clk),
    .rst  (i_rst),
    .en   (state != ST_IDLE),
    .clr  (state == ST_IDLE),
    .tick (tick)
  );

  // Protocol: i_start is a level request taken only in IDLE with a non-zero
  // length; o_busy covers the whole message and o_done marks its last cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      o_tx       <= 1'b1;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_char_idx <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      bit_cnt    <= '0;
      len_q      <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start && eff_len != '0) begin
            state      <= ST_START;
            o_tx       <= 1'b0;
            o_busy     <= 1'b1;
            o_char_idx <= '0;
            len_q      <= eff_len;
            shreg      <= buffer[0];
            par_bit    <= parity_of(buffer[0]);
          end
        end
        ST_START: begin
          if (tick) begin
            state   <= ST_DATA;
            o_tx    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (PARITY != PAR_NONE) begin
                state <= ST_PARITY;
                o_tx  <= par_bit;
              end else begin
                state <= ST_STOP;
                o_tx  <= 1'b1;
              end
            end else begin
              o_tx    <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state <= ST_STOP;
            o_tx  <= 1'b1;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (bit_cnt != LAST_STOP) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (!last_char) begin
              state      <= ST_START;
              o_tx       <= 1'b0;
              o_char_idx <= next_idx;
              shreg      <= buffer[next_idx];
              par_bit    <= parity_of(buffer[next_idx]);
            end else begin
              o_done <= 1'b1;
              if (i_repeat) begin
                state      <= ST_START;
                o_tx       <= 1'b0;
                o_char_idx <= '0;
                shreg      <= buffer[0];
                par_bit    <= parity_of(buffer[0]);
              end else begin
                state  <= ST_IDLE;
                o_tx   <= 1'b1;
                o_busy <= 1'b0;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_message_sender.sv
// Bench for uart_message_sender: three configurations (8N1 default, 7E2, 7O1)
// with a line-decoding monitor per instance checked against expected frames.
module tb_uart_message_sender;
  import uart_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, rst_b;

  // ---------------- DUT signals ----------------
  logic       a_wr_en, a_start, a_repeat, a_tx, a_busy, a_done;
  logic [2:0] a_wr_addr, a_idx;
  logic [7:0] a_wr_data;
  logic [3:0] a_len;
  uart_state_t a_state;

  logic       b_wr_en, b_start, b_repeat, b_tx, b_busy, b_done;
  logic [1:0] b_wr_addr, b_idx;
  logic [6:0] b_wr_data;
  logic [2:0] b_len;
  uart_state_t b_state;

  logic       c_wr_en, c_start, c_repeat, c_tx, c_busy, c_done;
  logic [2:0] c_wr_addr, c_idx;
  logic [6:0] c_wr_data;
  logic [3:0] c_len;
  uart_state_t c_state;

  logic [2:0] tx_w, busy_w, done_w, rst_w;
  assign tx_w   = {c_tx, b_tx, a_tx};
  assign busy_w = {c_busy, b_busy, a_busy};
  assign done_w = {c_done, b_done, a_done};
  assign rst_w  = {rst_b, rst_b, rst_a};

  uart_message_sender dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_wr_en(a_wr_en), .i_wr_addr(a_wr_addr),
    .i_wr_data(a_wr_data), .i_len(a_len), .i_start(a_start), .i_repeat(a_repeat),
    .o_tx(a_tx), .o_busy(a_busy), .o_done(a_done), .o_char_idx(a_idx), .o_state(a_state)
  );

  uart_message_sender #(
    .CLK_HZ(1_000_000), .BAUD(125_000), .DATA_BITS(7), .DEPTH(4), .PARITY(1), .STOP_BITS(2)
  ) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_wr_en(b_wr_en), .i_wr_addr(b_wr_addr),
    .i_wr_data(b_wr_data), .i_len(b_len), .i_start(b_start), .i_repeat(b_repeat),
    .o_tx(b_tx), .o_busy(b_busy), .o_done(b_done), .o_char_idx(b_idx), .o_state(b_state)
  );

  uart_message_sender #(
    .CLK_HZ(1_000_000), .BAUD(125_000), .DATA_BITS(7), .DEPTH(8), .PARITY(2), .STOP_BITS(1)
  ) dut_c (
    .i_clk(clk), .i_rst(rst_b), .i_wr_en(c_wr_en), .i_wr_addr(c_wr_addr),
    .i_wr_data(c_wr_data), .i_len(c_len), .i_start(c_start), .i_repeat(c_repeat),
    .o_tx(c_tx), .o_busy(c_busy), .o_done(c_done), .o_char_idx(c_idx), .o_state(c_state)
  );

  // Per-instance line format: bit period, data bits, parity mode, stop bits.
  int bc_k[3] = '{434, 8, 8};
  int db_k[3] = '{8, 7, 7};
  int pm_k[3] = '{0, 1, 2};
  int sb_k[3] = '{1, 2, 1};

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] exp_q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int frame_bits(input int k);
    return 1 + db_k[k] + ((pm_k[k] != 0) ? 1 : 0) + sb_k[k];
  endfunction

  function automatic int frame_cyc(input int k);
    return frame_bits(k) * bc_k[k];
  endfunction

  // Reference line image of one character: start 0, data LSB first,
  // optional parity, stop ones; bit 0 of the result is the first bit on the wire.
  function automatic logic [15:0] frame_of(input int k, input logic [8:0] d);
    logic [15:0] f;
    int n;
    int ones;
    f = '0;
    n = 1;
    ones = 0;
    for (int i = 0; i < db_k[k]; i++) begin
      f[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (pm_k[k] == 1) begin f[n] = (ones % 2) == 1; n++; end
    if (pm_k[k] == 2) begin f[n] = (ones % 2) == 0; n++; end
    for (int i = 0; i < sb_k[k]; i++) begin
      f[n] = 1'b1;
      n++;
    end
    return f;
  endfunction

  task automatic push(input int k, input logic [8:0] d);
    case (k)
      0:       exp_q0.push_back(frame_of(k, d));
      1:       exp_q1.push_back(frame_of(k, d));
      default: exp_q2.push_back(frame_of(k, d));
    endcase
  endtask

  task automatic pop_exp(input int k, output logic [15:0] e, output bit ok);
    ok = 1'b1;
    e  = '0;
    case (k)
      0:       if (exp_q0.size() > 0) e = exp_q0.pop_front(); else ok = 1'b0;
      1:       if (exp_q1.size() > 0) e = exp_q1.pop_front(); else ok = 1'b0;
      default: if (exp_q2.size() > 0) e = exp_q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // Decodes frames off the line at mid-bit; frames cut by reset are dropped.
  task automatic monitor(input int k);
    logic [15:0] got, e;
    bit ab, ok;
    int fl, wcyc;
    fl = frame_bits(k);
    forever begin
      @(negedge clk);
      if (tx_w[k] === 1'b0 && rst_w[k] === 1'b0) begin
        got = '0;
        ab  = 1'b0;
        for (int j = 0; j < fl; j++) begin
          wcyc = (j == 0) ? bc_k[k] / 2 - 1 : bc_k[k];
          for (int c = 0; c < wcyc; c++) begin
            @(negedge clk);
            if (rst_w[k] !== 1'b0) ab = 1'b1;
          end
          if (ab) break;
          got[j] = tx_w[k];
        end
        if (!ab) begin
          pop_exp(k, e, ok);
          if (!ok) begin
            total++;
            bad++;
            $display("FAIL frame_%0d_unexpected: got %0h expected none", k, got);
          end else begin
            check($sformatf("frame_%0d", k), got, e);
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int k, input int addr, input logic [8:0] d);
    case (k)
      0:       begin a_wr_en = 1'b1; a_wr_addr = 3'(addr); a_wr_data = 8'(d); end
      1:       begin b_wr_en = 1'b1; b_wr_addr = 2'(addr); b_wr_data = 7'(d); end
      default: begin c_wr_en = 1'b1; c_wr_addr = 3'(addr); c_wr_data = 7'(d); end
    endcase
    tick();
    a_wr_en = 1'b0;
    b_wr_en = 1'b0;
    c_wr_en = 1'b0;
  endtask

  task automatic start(input int k, input int len);
    case (k)
      0:       begin a_len = 4'(len); a_start = 1'b1; end
      1:       begin b_len = 3'(len); b_start = 1'b1; end
      default: begin c_len = 4'(len); c_start = 1'b1; end
    endcase
    tick();
    a_start = 1'b0;
    b_start = 1'b0;
    c_start = 1'b0;
  endtask

  task automatic msg_check(input int k, input int len, input string name);
    int n;
    check({name, "_busy"}, busy_w[k], 1);
    n = 0;
    while (done_w[k] !== 1'b1 && n < len * frame_cyc(k) + 100) begin
      tick();
      n++;
    end
    check({name, "_cycles"}, n, len * frame_cyc(k));
    check({name, "_end_busy"}, busy_w[k], 0);
    tick();
    check({name, "_done_width"}, done_w[k], 0);
  endtask

  task automatic no_busy(input int k, input string name);
    int hits;
    hits = 0;
    repeat (5) begin
      if (busy_w[k] !== 1'b0 || done_w[k] !== 1'b0) hits++;
      tick();
    end
    check(name, hits, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] hello [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    logic [8:0] v [4];
    logic [8:0] n3;
    int n, lows, d, t1, t2, t3, len;
    bit wrote;

    a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0; a_repeat = 0;
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_repeat = 0;
    c_wr_en = 0; c_wr_addr = 0; c_wr_data = 0; c_repeat = 0;
    rst_a = 1; rst_b = 1;
    a_start = 1; b_start = 1; c_start = 1;
    a_len = 5; b_len = 1; c_len = 1;

    // Reset held with start asserted: line stays idle.
    lows = 0;
    repeat (6) begin
      tick();
      if (tx_w !== 3'b111 || busy_w !== 3'b000 || done_w !== 3'b000) lows++;
    end
    check("reset_quiet", lows, 0);
    check("reset_idx", a_idx, 0);
    check("reset_state", a_state, ST_IDLE);
    a_start = 0; b_start = 0; c_start = 0;
    tick();
    rst_a = 0; rst_b = 0;
    tick();

    // "Hello", 8N1.
    for (int i = 0; i < 5; i++) begin
      wr(0, i, 9'(hello[i]));
      push(0, 9'(hello[i]));
    end
    start(0, 5);
    msg_check(0, 5, "hello");

    // Zero length is ignored.
    start(0, 0);
    no_busy(0, "a_len0");

    // Overwrite index 3 while index 1 is on the line; start/len pokes while busy.
    for (int i = 0; i < 4; i++) begin
      v[i] = 9'($urandom_range(0, 255));
      wr(0, i, v[i]);
    end
    for (int i = 0; i < 3; i++) push(0, v[i]);
    n3 = ~v[3] & 9'h0FF;
    start(0, 4);
    check("a_idx_first", a_idx, 0);
    check("a_busy_first", a_busy, 1);
    n = 0;
    wrote = 0;
    while (a_done !== 1'b1 && n < 20000) begin
      a_wr_en = 0;
      a_start = 0;
      if (!wrote && a_idx == 3'd1) begin
        a_wr_en = 1; a_wr_addr = 3; a_wr_data = 8'(n3);
        push(0, n3);
        a_start = 1; a_len = 1;
        wrote = 1;
      end
      tick();
      n++;
    end
    a_wr_en = 0;
    a_start = 0;
    check("a_wrote_mid", wrote, 1);
    check("a_msg4_cycles", n, 4 * frame_cyc(0));
    tick();

    // Reset halfway through the second data bit.
    start(0, 3);
    repeat (2 * bc_k[0] + bc_k[0] / 2 - 1) tick();
    #1 rst_a = 1;
    #1;
    check("rst_tx_async", a_tx, 1);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    repeat (3) tick();
    rst_a = 0;
    tick();
    check("rst_state_idle", a_state, ST_IDLE);
    no_busy(0, "rst_after_quiet");
    push(0, v[0]);
    start(0, 1);
    check("rst_restart_idx", a_idx, 0);
    msg_check(0, 1, "rst_restart");

    // 7E2 and 7O1 with 0x07.
    wr(1, 0, 9'h07);
    wr(2, 0, 9'h07);
    push(1, 9'h07);
    push(2, 9'h07);
    start(1, 1);
    msg_check(1, 1, "even7");
    start(2, 1);
    msg_check(2, 1, "odd7");

    // Length above DEPTH clamps to DEPTH.
    for (int i = 0; i < 4; i++) begin
      v[i] = 9'($urandom_range(0, 127));
      wr(1, i, v[i]);
      push(1, v[i]);
    end
    start(1, 7);
    msg_check(1, 4, "clamp");

    // Repeat mode: three passes, repeat dropped after the second done.
    v[0] = 9'($urandom_range(0, 127));
    v[1] = 9'($urandom_range(0, 127));
    wr(1, 0, v[0]);
    wr(1, 1, v[1]);
    repeat (3) begin
      push(1, v[0]);
      push(1, v[1]);
    end
    b_repeat = 1;
    start(1, 2);
    n = 0; d = 0; lows = 0; t1 = 0; t2 = 0; t3 = 0;
    while (d < 3 && n < 2000) begin
      tick();
      n++;
      if (b_done === 1'b1) begin
        d++;
        if (d == 1) t1 = n;
        if (d == 2) begin t2 = n; b_repeat = 0; end
        if (d == 3) begin t3 = n; check("rep_end_busy", b_busy, 0); end
      end
      if (d < 3 && b_busy !== 1'b1) lows++;
    end
    b_repeat = 0;
    check("rep_done_count", d, 3);
    check("rep_first_done", t1, 2 * frame_cyc(1));
    check("rep_gap1", t2 - t1, 2 * frame_cyc(1));
    check("rep_gap2", t3 - t2, 2 * frame_cyc(1));
    check("rep_busy_lows", lows, 0);
    tick();
    check("rep_idle", b_state, ST_IDLE);

    // Random messages on the 7O1 instance.
    for (int m = 0; m < 4; m++) begin
      len = (m == 0) ? 0 : int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) begin
        v[0] = 9'($urandom_range(0, 127));
        wr(2, i, v[0]);
        push(2, v[0]);
      end
      start(2, len);
      if (len == 0) no_busy(2, "c_len0");
      else msg_check(2, len, $sformatf("c_msg%0d", m));
    end

    n = 0;
    while ((exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0 && n < 2000) begin
      tick();
      n++;
    end
    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);
    check("q2_drained", exp_q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
